fetch_stage: RTL and testbench

Instruction-fetch stage that owns the PC register, runs a req/ack handshake with a variable-latency instruction memory, and produces the IF/ID pipeline register. It sits directly downstream of the branch target buffer. It exports `current_pc` to the BTB and takes back the predicted or redirected `pred_next_pc` and `is_flush`. It also absorbs load-use stalls from the hazard unit and discards in-flight fetches made stale by a redirect.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage: PC register, req/ack instruction-memory handshake and IF/ID register.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pred_next_pc,
    input  logic        is_flush,
    input  logic        stall_if_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] current_pc,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] discard_addr;
    logic [31:0] buf_inst;
    logic [31:0] next_target;
    logic        unused_pred_lsbs;

    assign next_target      = {pred_next_pc[31:2], 2'b00};
    assign unused_pred_lsbs = &{1'b0, pred_next_pc[1:0]};

    assign current_pc = pc;
    assign imem_req   = !reset && (state != HOLD);
    // In DISCARD the bus still carries the stale request until its ack arrives
    assign imem_addr  = (state == DISCARD) ? discard_addr : pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= {RESET_PC[31:2], 2'b00};
            discard_addr <= 32'h0;
            buf_inst     <= NOP_INST;
            IF_ID_pc     <= 32'h0;
            IF_ID_inst   <= NOP_INST;
            IF_ID_valid  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (is_flush) begin
                        IF_ID_pc    <= 32'h0;
                        IF_ID_inst  <= NOP_INST;
                        IF_ID_valid <= 1'b0;
                        pc          <= next_target;
                        if (!imem_ack) begin
                            discard_addr <= pc;
                            state        <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        if (stall_if_id) begin
                            buf_inst <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            IF_ID_pc    <= pc;
                            IF_ID_inst  <= imem_rdata;
                            IF_ID_valid <= 1'b1;
                            pc          <= next_target;
                        end
                    end else if (!stall_if_id) begin
                        IF_ID_pc    <= 32'h0;
                        IF_ID_inst  <= NOP_INST;
                        IF_ID_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (is_flush) begin
                        IF_ID_pc    <= 32'h0;
                        IF_ID_inst  <= NOP_INST;
                        IF_ID_valid <= 1'b0;
                        pc          <= next_target;
                        state       <= FETCH;
                    end else if (!stall_if_id) begin
                        IF_ID_pc    <= pc;
                        IF_ID_inst  <= buf_inst;
                        IF_ID_valid <= 1'b1;
                        pc          <= next_target;
                        state       <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                    if (is_flush) begin
                        pc <= next_target;
                    end
                    if (is_flush || !stall_if_id) begin
                        IF_ID_pc    <= 32'h0;
                        IF_ID_inst  <= NOP_INST;
                        IF_ID_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// tb_fetch_stage: directed and random checks of fetch_stage against a queue-based model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pred_next_pc;
    logic        is_flush;
    logic        stall_if_id;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] current_pc;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;

    fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_INST(TB_NOP)) dut (
        .clk(clk), .reset(reset), .pred_next_pc(pred_next_pc), .is_flush(is_flush),
        .stall_if_id(stall_if_id), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .current_pc(current_pc),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the PC, the address of a fetch whose data must be thrown
    // away (if any), instructions parked while ID is stalled, and the ID slot.
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_old;
    logic [31:0] m_buf[$];
    logic [31:0] m_ipc, m_iinst;
    logic        m_ival;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_ipc = 32'h0; m_iinst = TB_NOP; m_ival = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = {TB_RESET_PC[31:2], 2'b00};
        m_stale = 1'b0; m_old = 32'h0;
        m_buf.delete();
        bubble();
    endtask

    // One clock: apply inputs, check request side, clock, check registered side.
    task automatic cyc(input logic r, input logic f, input logic s, input logic a,
                       input logic [31:0] d, input logic [31:0] p);
        logic        exp_req;
        logic [31:0] exp_addr, tgt;
        reset = r; is_flush = f; stall_if_id = s; imem_ack = a;
        imem_rdata = d; pred_next_pc = p;
        exp_req  = !r && (m_buf.size() == 0);
        exp_addr = m_stale ? m_old : m_pc;
        #1;
        chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        @(posedge clk);
        tgt = {p[31:2], 2'b00};
        if (r) begin
            model_reset();
        end else if (m_stale) begin
            if (a) m_stale = 1'b0;
            if (f) m_pc = tgt;
            if (f || !s) bubble();
        end else if (m_buf.size() != 0) begin
            if (f) begin
                m_buf.delete(); bubble(); m_pc = tgt;
            end else if (!s) begin
                m_ipc = m_pc; m_iinst = m_buf.pop_front(); m_ival = 1'b1; m_pc = tgt;
            end
        end else begin
            if (f) begin
                bubble();
                if (!a) begin m_stale = 1'b1; m_old = m_pc; end
                m_pc = tgt;
            end else if (a) begin
                if (s) m_buf.push_back(d);
                else begin m_ipc = m_pc; m_iinst = d; m_ival = 1'b1; m_pc = tgt; end
            end else if (!s) begin
                bubble();
            end
        end
        #1;
        chk("current_pc", current_pc, m_pc);
        chk("IF_ID_pc", IF_ID_pc, m_ipc);
        chk("IF_ID_inst", IF_ID_inst, m_iinst);
        chk("IF_ID_valid", {31'h0, IF_ID_valid}, {31'h0, m_ival});
    endtask

    initial begin
        logic        r, f, s, a;
        logic [31:0] p, d;

        reset = 1'b1; is_flush = 1'b0; stall_if_id = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; pred_next_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        chk("reset_pc", current_pc, TB_RESET_PC);
        chk("reset_valid", {31'h0, IF_ID_valid}, 32'h0);
        chk("reset_inst", IF_ID_inst, TB_NOP);

        // Zero-wait memory with a sequential BTB
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, mem(m_pc), m_pc + 32'd4);
            chk("seq_pc", IF_ID_pc, TB_RESET_PC + 32'(i * 4));
        end

        // Two-cycle memory
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 32'hBAD0_0000, m_pc + 32'd4);
            chk("lat2_bubble", {31'h0, IF_ID_valid}, 32'h0);
            cyc(0, 0, 0, 1, mem(m_pc), m_pc + 32'd4);
            chk("lat2_valid", {31'h0, IF_ID_valid}, 32'h1);
        end

        // Stall with ack of pc 0x10
        cyc(0, 1, 0, 1, 32'h0BAD_0BAD, 32'h0000_000C);
        cyc(0, 0, 0, 1, mem(32'hC), 32'h0000_0010);
        cyc(0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0000_0014);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0, 32'hBAD1_BAD1, 32'h0000_0014);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_ifid", IF_ID_pc, 32'h0000_000C);
        end
        cyc(0, 0, 0, 0, 32'hBAD2_BAD2, 32'h0000_0014);
        chk("unstall_pc", IF_ID_pc, 32'h0000_0010);
        chk("unstall_inst", IF_ID_inst, 32'hDEAD_BEEF);

        // Flush while a fetch of 0x20 is outstanding
        cyc(0, 1, 0, 1, 32'h0BAD_0BAD, 32'h0000_0020);
        cyc(0, 0, 0, 0, 32'hBAD3_BAD3, 32'h0000_0024);
        cyc(0, 1, 0, 0, 32'hBAD4_BAD4, 32'h0000_0100);
        chk("redir_pc", current_pc, 32'h0000_0100);
        chk("stale_addr", imem_addr, 32'h0000_0020);
        cyc(0, 0, 0, 0, 32'hBAD5_BAD5, 32'h0000_0104);
        cyc(0, 0, 0, 1, 32'h5A1E_5A1E, 32'h0000_0104);
        chk("stale_dropped", {31'h0, IF_ID_valid}, 32'h0);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        cyc(0, 0, 0, 1, mem(32'h100), 32'h0000_0104);
        chk("redir_ifid", IF_ID_pc, 32'h0000_0100);

        // Flush and stall together while in HOLD
        cyc(0, 0, 1, 1, 32'hCAFE_0001, m_pc + 32'd4);
        cyc(0, 1, 1, 0, 32'hBAD6_BAD6, 32'h0000_0040);
        chk("hflush_valid", {31'h0, IF_ID_valid}, 32'h0);
        chk("hflush_addr", imem_addr, 32'h0000_0040);
        cyc(0, 0, 0, 1, mem(32'h40), 32'h0000_0044);
        chk("hflush_inst", IF_ID_inst, mem(32'h40));

        // Reset while in DISCARD
        cyc(0, 0, 0, 0, 32'hBAD7_BAD7, m_pc + 32'd4);
        cyc(0, 1, 0, 0, 32'hBAD8_BAD8, 32'h0000_0200);
        cyc(1, 0, 0, 0, 32'hBAD9_BAD9, 32'h0000_0200);
        chk("mrst_pc", current_pc, TB_RESET_PC);
        chk("mrst_valid", {31'h0, IF_ID_valid}, 32'h0);
        cyc(0, 0, 0, 1, mem(TB_RESET_PC), TB_RESET_PC + 32'd4);
        chk("mrst_ack_pc", IF_ID_pc, TB_RESET_PC);

        // Random traffic: variable-latency memory, random redirects and stalls
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            a = (m_buf.size() == 0) && ($urandom_range(0, 1) == 1);
            d = a ? mem(m_stale ? m_old : m_pc) : $urandom;
            if (f || $urandom_range(0, 9) == 0) p = $urandom;
            else p = m_pc + 32'd4;
            cyc(r, f, s, a, d, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
